// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared encodings and frame layout for the MDIO master
// Clause-22 field positions inside the 32-bit frame, plus the frame builder.
package mdio_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SEND,
        S_READ,
        S_DONE
    } mdio_state_e;

    localparam logic [1:0] ST_CODE = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] TA_WR   = 2'b10;

    localparam int FRAME_BITS = 32;
    localparam int DATA_BITS  = 16;

    localparam int POS_ST   = 30;
    localparam int POS_OP   = 28;
    localparam int POS_PHY  = 23;
    localparam int POS_REG  = 18;
    localparam int POS_TA   = 16;
    localparam int POS_DATA = 0;

    // Read frames carry zeros in the data field; those bits are never driven.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic                 wr,
        input logic [4:0]           phy_addr,
        input logic [4:0]           reg_addr,
        input logic [DATA_BITS-1:0] wdata
    );
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[POS_ST +: 2]          = ST_CODE;
        f[POS_OP +: 2]          = wr ? OP_WR : OP_RD;
        f[POS_PHY +: 5]         = phy_addr;
        f[POS_REG +: 5]         = reg_addr;
        f[POS_TA +: 2]          = TA_WR;
        f[POS_DATA +: DATA_BITS] = wr ? wdata : '0;
        return f;
    endfunction

endpackage

// File: rtl/mdio_rr_arbiter.sv
// rtl/mdio_rr_arbiter.sv - round-robin arbiter with rotating pointer
// Grants the first requester at or after the pointer; pointer advances past the winner.
module mdio_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic                       enable,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        int   idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        ptr_d     = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
        if (enable && found) begin
            grant[grant_idx] = 1'b1;
            ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/controlador_mdio.sv
// rtl/controlador_mdio.sv - shared Clause-22 MDIO master with round-robin requesters
// Optional 32-bit preamble before each frame when MDIO_PREAMBLE_EN is defined.
module controlador_mdio
    import mdio_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int MDC_DIV = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [5*NUM_REQ-1:0]   req_phy_addr,
    input  logic [5*NUM_REQ-1:0]   req_reg_addr,
    input  logic [16*NUM_REQ-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [DATA_BITS-1:0]   rsp_rdata,
    output logic                   busy,
    output logic                   mdc,
    output logic                   mdio_out,
    output logic                   mdio_oe,
    input  logic                   mdio_in
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int DIV_W = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;

    mdio_state_e            state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic                   mdc_q, mdc_d;
    logic                   out_q, out_d;
    logic                   oe_q, oe_d;
    logic [4:0]             bit_q, bit_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]   rx_q, rx_d;
    logic [DATA_BITS-1:0]   rdata_q, rdata_d;
    logic                   wr_q, wr_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    logic [NUM_REQ-1:0]     rsp_q, rsp_d;

    logic                   arb_en;
    logic [NUM_REQ-1:0]     grant;
    logic [IDX_W-1:0]       grant_idx;
    logic [FRAME_BITS-1:0]  frame;
    logic                   tick, rise, fall;

    // Gating with reset keeps req_ready/busy low while reset is held.
    assign arb_en = (state_q == S_IDLE) && reset;

    mdio_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign busy      = (state_q != S_IDLE) || (|grant);
    assign rsp_valid = rsp_q;
    assign rsp_rdata = rdata_q;
    assign mdc       = mdc_q;
    assign mdio_out  = out_q;
    assign mdio_oe   = oe_q;

    assign tick = (div_q == DIV_W'(MDC_DIV - 1));
    assign rise = tick && !mdc_q;
    assign fall = tick && mdc_q;

    always_comb begin
        int gsel;
        gsel    = int'(grant_idx);
        frame   = build_frame(req_write[grant_idx], req_phy_addr[gsel*5 +: 5],
                              req_reg_addr[gsel*5 +: 5], req_wdata[gsel*16 +: 16]);
        state_d = state_q;
        div_d   = div_q;
        mdc_d   = mdc_q;
        out_d   = out_q;
        oe_d    = oe_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        gidx_d  = gidx_q;
        rsp_d   = '0;

        if (state_q == S_PREAMBLE || state_q == S_SEND || state_q == S_READ) begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                mdc_d = ~mdc_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (|grant) begin
                    wr_d    = req_write[grant_idx];
                    gidx_d  = grant_idx;
                    shift_d = frame;
                    div_d   = '0;
                    mdc_d   = 1'b0;
                    bit_d   = '0;
                    oe_d    = 1'b1;
`ifdef MDIO_PREAMBLE_EN
                    state_d = S_PREAMBLE;
                    out_d   = 1'b1;
`else
                    state_d = S_SEND;
                    out_d   = frame[FRAME_BITS-1];
`endif
                end
            end
`ifdef MDIO_PREAMBLE_EN
            S_PREAMBLE: begin
                if (fall) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 5'd31) begin
                        state_d = S_SEND;
                        out_d   = shift_q[FRAME_BITS-1];
                    end
                end
            end
`endif
            S_SEND: begin
                if (fall) begin
                    bit_d   = bit_q + 1'b1;
                    shift_d = shift_q << 1;
                    out_d   = shift_q[FRAME_BITS-2];
                    // Reads release the bus after the turnaround field.
                    if (!wr_q && bit_q == 5'd15) begin
                        state_d = S_READ;
                        oe_d    = 1'b0;
                        out_d   = 1'b0;
                    end else if (bit_q == 5'd31) begin
                        state_d       = S_DONE;
                        oe_d          = 1'b0;
                        out_d         = 1'b0;
                        rsp_d[gidx_q] = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (rise) begin
                    rx_d = {rx_q[DATA_BITS-2:0], mdio_in};
                end
                if (fall) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 5'd31) begin
                        state_d       = S_DONE;
                        rdata_d       = rx_q;
                        rsp_d[gidx_q] = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            mdc_q   <= 1'b0;
            out_q   <= 1'b0;
            oe_q    <= 1'b0;
            bit_q   <= '0;
            shift_q <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            gidx_q  <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            mdc_q   <= mdc_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            gidx_q  <= gidx_d;
            rsp_q   <= rsp_d;
        end
    end

endmodule

// File: tb/tb_controlador_mdio.sv
// tb/tb_controlador_mdio.sv - directed self-checking bench for controlador_mdio
// Expected frames and latencies are hand-derived from the Clause-22 layout.
module tb_controlador_mdio;

    localparam int NUM_REQ = 2;
    localparam int MDC_DIV = 2;
`ifdef MDIO_PREAMBLE_EN
    localparam int PRE = 32;
`else
    localparam int PRE = 0;
`endif
    localparam int LAT = 1 + 64*MDC_DIV + 2*PRE*MDC_DIV;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_write = '0;
    logic [5*NUM_REQ-1:0]  req_phy_addr = '0;
    logic [5*NUM_REQ-1:0]  req_reg_addr = '0;
    logic [16*NUM_REQ-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [15:0]           rsp_rdata;
    logic                  busy, mdc, mdio_out, mdio_oe;
    logic                  mdio_in = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    controlador_mdio #(.NUM_REQ(NUM_REQ), .MDC_DIV(MDC_DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_phy_addr (req_phy_addr),
        .req_reg_addr (req_reg_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .busy         (busy),
        .mdc          (mdc),
        .mdio_out     (mdio_out),
        .mdio_oe      (mdio_oe),
        .mdio_in      (mdio_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input string tag, input logic [1:0] exp);
        int n;
        n = 0;
        #1;
        while (req_ready == 2'b00 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_grant"}, 64'(req_ready), 64'(exp));
        check({tag, "_busy_at_grant"}, 64'(busy), 64'd1);
    endtask

    // Follows one frame from its grant cycle to the rsp_valid cycle, acting as the PHY.
    task automatic run_frame(input logic [15:0] phy_data, input logic [1:0] clr_mask,
                             input logic [1:0] pulse_mask, input int pulse_at,
                             output logic [63:0] cap, output int lat, output int oe_rises,
                             output int grants, output logic [1:0] rsp);
        logic prev;
        int   falls;
        prev = mdc; falls = 0;
        cap = '0; lat = 0; oe_rises = 0; grants = 0; rsp = '0;
        while (rsp == 2'b00 && lat < LAT + 50) begin
            @(negedge clk);
            lat++;
            if (lat == 1) req_valid = req_valid & ~clr_mask;
            if (lat == pulse_at) req_valid = req_valid | pulse_mask;
            if (lat == pulse_at + 3) req_valid = req_valid & ~pulse_mask;
            if (mdc && !prev) begin
                cap = {cap[62:0], mdio_out};
                if (mdio_oe) oe_rises++;
            end
            if (!mdc && prev) begin
                falls++;
                if (falls >= PRE + 16 && falls < PRE + 32) mdio_in = phy_data[PRE + 31 - falls];
            end
            prev = mdc;
            if (req_ready != 2'b00) grants++;
            rsp = rsp_valid;
        end
    endtask

    initial begin
        logic [63:0] cap;
        int          lat, oe_rises, grants, falls, n;
        logic [1:0]  rsp, exp_g;
        logic        prev;

        repeat (3) @(negedge clk);
        check("rst_mdc", 64'(mdc), 64'd0);
        check("rst_oe", 64'(mdio_oe), 64'd0);
        check("rst_out", 64'(mdio_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_rsp", 64'(rsp_valid), 64'd0);
        check("rst_rdata", 64'(rsp_rdata), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Write from requester 0: frame 01 01 00001 00011 10 A5C3
        req_write = 2'b01; req_phy_addr[4:0] = 5'h01; req_reg_addr[4:0] = 5'h03;
        req_wdata[15:0] = 16'hA5C3; req_valid = 2'b01;
        wait_grant("wr", 2'b01);
        run_frame(16'h0, 2'b01, 2'b00, -1, cap, lat, oe_rises, grants, rsp);
        check("wr_bits", 64'(cap[31:0]), 64'h508EA5C3);
`ifdef MDIO_PREAMBLE_EN
        check("wr_preamble", 64'(cap[63:32]), 64'hFFFFFFFF);
`endif
        check("wr_latency", 64'(lat), 64'(LAT));
        check("wr_oe_rises", 64'(oe_rises), 64'(32 + PRE));
        check("wr_rsp", 64'(rsp), 64'h1);
        check("wr_busy_done", 64'(busy), 64'd1);
        check("wr_rdata_unchanged", 64'(rsp_rdata), 64'h0);
        @(negedge clk);
        check("wr_idle_busy", 64'(busy), 64'd0);
        check("wr_idle_rsp", 64'(rsp_valid), 64'd0);
        check("wr_idle_mdc", 64'(mdc), 64'd0);

        // Read from requester 1: command half 01 10 00010 11111 10
        req_write = 2'b00; req_phy_addr[9:5] = 5'h02; req_reg_addr[9:5] = 5'h1F;
        req_valid = 2'b10;
        wait_grant("rd", 2'b10);
        run_frame(16'h1234, 2'b10, 2'b00, -1, cap, lat, oe_rises, grants, rsp);
        check("rd_cmd_bits", 64'(cap[31:16]), 64'h617E);
        check("rd_oe_rises", 64'(oe_rises), 64'(16 + PRE));
        check("rd_latency", 64'(lat), 64'(LAT));
        check("rd_rsp", 64'(rsp), 64'h2);
        check("rd_rdata", 64'(rsp_rdata), 64'h1234);
        @(negedge clk);
        check("rd_rdata_held", 64'(rsp_rdata), 64'h1234);
        check("rd_idle_busy", 64'(busy), 64'd0);

        // Both held: pointer is back at 0, so grants alternate 0,1,0,1
        req_write = 2'b11; req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            wait_grant($sformatf("rr%0d", i), exp_g);
            run_frame(16'h0, 2'b00, 2'b00, -1, cap, lat, oe_rises, grants, rsp);
            check($sformatf("rr%0d_rsp", i), 64'(rsp), 64'(exp_g));
            check($sformatf("rr%0d_latency", i), 64'(lat), 64'(LAT));
            check($sformatf("rr%0d_no_overlap", i), 64'(grants), 64'd0);
            @(negedge clk);
        end
        req_valid = 2'b00;
        @(negedge clk);
        check("rr_rdata_held", 64'(rsp_rdata), 64'h1234);

        // Requester 1 pulses for three cycles mid-frame and is never served
        req_valid = 2'b01;
        wait_grant("wd", 2'b01);
        run_frame(16'h0, 2'b01, 2'b10, 20, cap, lat, oe_rises, grants, rsp);
        check("wd_no_grant", 64'(grants), 64'd0);
        check("wd_rsp", 64'(rsp), 64'h1);
        @(negedge clk);
        check("wd_idle_busy", 64'(busy), 64'd0);
        check("wd_idle_ready", 64'(req_ready), 64'd0);

        // Pointer is at 1 here, so a lone requester 0 exercises the wrap
        req_valid = 2'b01;
        wait_grant("rst", 2'b01);
        prev = mdc; falls = 0; n = 0;
        while (falls < PRE + 10 && n < 1000) begin
            @(negedge clk);
            n++;
            if (n == 1) req_valid = 2'b00;
            if (!mdc && prev) falls++;
            prev = mdc;
        end
        check("rst_reached_bit10", 64'(falls), 64'(PRE + 10));
        reset = 1'b0;
        #1;
        check("rst_mid_mdc", 64'(mdc), 64'd0);
        check("rst_mid_oe", 64'(mdio_oe), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_rsp", 64'(rsp_valid), 64'd0);
        repeat (2) @(negedge clk);
        check("rst_hold_rsp", 64'(rsp_valid), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_after_busy", 64'(busy), 64'd0);

        // Pointer cleared by reset: with both requesting, requester 0 wins
        req_valid = 2'b11;
        wait_grant("post", 2'b01);
        run_frame(16'h0, 2'b11, 2'b00, -1, cap, lat, oe_rises, grants, rsp);
        check("post_bits", 64'(cap[31:0]), 64'h508EA5C3);
        check("post_latency", 64'(lat), 64'(LAT));
        check("post_rsp", 64'(rsp), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
